barrel_unshifter: RTL and testbench

BARREL_UNSHIFTER -- requirements
Module: barrel_unshifter

---
 rtl/barrel_unshifter_if.sv | 25 ++
 rtl/barrel_unshifter.sv | 88 ++++++++
 tb/tb_barrel_unshifter.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/barrel_unshifter_if.sv
// Handshake bundle for barrel_unshifter: shifted words in, restored words out,
// plus the delivered-word counter.
interface barrel_unshifter_if #(
  parameter int CNT_W = 8
) ();
  logic             in_valid;
  logic             in_ready;
  logic [3:0]       in_data;
  logic [1:0]       in_shift;
  logic             out_valid;
  logic             out_ready;
  logic [3:0]       out_data;
  logic [1:0]       out_shift;
  logic [CNT_W-1:0] word_cnt;

  modport master (
    output in_valid, in_data, in_shift, out_ready,
    input  in_ready, out_valid, out_data, out_shift, word_cnt
  );

  modport slave (
    input  in_valid, in_data, in_shift, out_ready,
    output in_ready, out_valid, out_data, out_shift, word_cnt
  );
endinterface

// File: rtl/barrel_unshifter.sv
// Undoes a 1-bit rotation selected by a 2-bit code, then buffers the restored
// word and its code in a 2-entry FIFO; counts delivered words with saturation.
module barrel_unshifter #(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  barrel_unshifter_if.slave bus
);

  typedef struct packed {
    logic [3:0] data;
    logic [1:0] shift;
  } entry_t;

  entry_t           mem_q [2];
  entry_t           mem_d [2];
  logic [1:0]       occ_q, occ_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             push, pop;

  // Code 01 was a left rotate, 11 a right rotate; 00/10 left the word alone.
  function automatic logic [3:0] unshift(input logic [3:0] d, input logic [1:0] code);
    case (code)
      2'b01:   return {d[0], d[3:1]};
      2'b11:   return {d[2:0], d[3]};
      default: return d;
    endcase
  endfunction

  // in_ready comes only from occupancy so out_ready never reaches it.
  assign bus.in_ready  = (occ_q < 2'd2);
  assign bus.out_valid = (occ_q != 2'd0);
  assign bus.out_data  = bus.out_valid ? mem_q[rd_ptr_q].data  : 4'd0;
  assign bus.out_shift = bus.out_valid ? mem_q[rd_ptr_q].shift : 2'd0;
  assign bus.word_cnt  = cnt_q;

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_comb begin
    // NOTE: every _d gets its hold value first so no path can infer a latch.
    mem_d    = mem_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (push) begin
      mem_d[wr_ptr_q] = '{data: unshift(bus.in_data, bus.in_shift), shift: bus.in_shift};
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      if (cnt_q != {CNT_W{1'b1}}) cnt_d = cnt_q + CNT_W'(1);
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; empty-FIFO outputs are masked to 0.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_barrel_unshifter.sv
// Directed-vector bench for barrel_unshifter: stimulus pushes expected words
// into a queue, a negedge monitor pops and compares on each output handshake.
module tb_barrel_unshifter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  barrel_unshifter_if #(.CNT_W(8)) bus ();
  barrel_unshifter_if #(.CNT_W(2)) bus2 ();

  barrel_unshifter #(.CNT_W(8)) dut  (.clk(clk), .rst(rst), .bus(bus));
  barrel_unshifter #(.CNT_W(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  int n_cmp = 0;
  int n_err = 0;
  logic [5:0] exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for one edge; accept says whether the FIFO has room.
  task automatic send(input logic [3:0] d, input logic [1:0] s,
                      input logic [3:0] exp, input bit accept);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_shift = s;
    check("in_ready", {31'd0, bus.in_ready}, {31'd0, accept});
    if (accept) exp_q.push_back({exp, s});
    step();
  endtask

  // Scoreboard monitor: handshake inputs are stable at the falling edge.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard: unexpected word %0h with empty queue", {bus.out_data, bus.out_shift});
      end else begin
        check("scoreboard", {26'd0, bus.out_data, bus.out_shift}, {26'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // Directed words for the push+pop streaming phase: {in_data, in_shift, restored}.
  logic [9:0] stream_tbl [4] = '{
    {4'b1000, 2'b01, 4'b0100},
    {4'b1000, 2'b11, 4'b0001},
    {4'b1010, 2'b10, 4'b1010},
    {4'b0111, 2'b00, 4'b0111}
  };

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = 4'd0;
    bus.in_shift   = 2'd0;
    bus.out_ready  = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = 4'd0;
    bus2.in_shift  = 2'd0;
    bus2.out_ready = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    step();

    // Reset state
    check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst_out_data",  {28'd0, bus.out_data},  32'd0);
    check("rst_out_shift", {30'd0, bus.out_shift}, 32'd0);
    check("rst_word_cnt",  {24'd0, bus.word_cnt},  32'd0);

    // Single word, one-cycle latency
    bus.out_ready = 1'b1;
    send(4'b1001, 2'b01, 4'b1100, 1'b1);
    bus.in_valid = 1'b0;
    check("lat_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("lat_out_data",  {28'd0, bus.out_data},  32'b1100);
    check("lat_out_shift", {30'd0, bus.out_shift}, 32'b01);
    step();
    check("cnt_after_1", {24'd0, bus.word_cnt}, 32'd1);
    check("empty_again", {31'd0, bus.out_valid}, 32'd0);

    // Back-to-back codes 11, 00, 10 on the same data
    send(4'b0110, 2'b11, 4'b1100, 1'b1);
    check("seq0_data", {28'd0, bus.out_data}, 32'b1100);
    send(4'b0110, 2'b00, 4'b0110, 1'b1);
    check("seq1_data", {28'd0, bus.out_data}, 32'b0110);
    send(4'b0110, 2'b10, 4'b0110, 1'b1);
    check("seq2_data", {28'd0, bus.out_data}, 32'b0110);
    bus.in_valid = 1'b0;
    step();
    check("cnt_after_4", {24'd0, bus.word_cnt}, 32'd4);

    // Back-pressure: third word refused, head word held stable
    bus.out_ready = 1'b0;
    send(4'b0011, 2'b01, 4'b1001, 1'b1);
    check("hold0_data", {28'd0, bus.out_data}, 32'b1001);
    send(4'b0101, 2'b11, 4'b1010, 1'b1);
    check("hold1_data", {28'd0, bus.out_data}, 32'b1001);
    send(4'b1111, 2'b00, 4'b1111, 1'b0);
    check("hold2_data",  {28'd0, bus.out_data},  32'b1001);
    check("hold2_shift", {30'd0, bus.out_shift}, 32'b01);

    // Full with push and pop offered: only the pop happens
    bus.out_ready = 1'b1;
    send(4'b1111, 2'b00, 4'b1111, 1'b0);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("full_pop_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("full_pop_out_valid", {31'd0, bus.out_valid}, 32'd1);
    check("full_pop_head",      {28'd0, bus.out_data},  32'b1010);
    check("cnt_after_5",        {24'd0, bus.word_cnt},  32'd5);

    // Occupancy 1, simultaneous push and pop for 10 cycles
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(stream_tbl[i%4][9:6], stream_tbl[i%4][5:4], stream_tbl[i%4][3:0], 1'b1);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("stream_cnt",       {24'd0, bus.word_cnt},  32'd15);
    check("stream_occ_valid", {31'd0, bus.out_valid}, 32'd1);
    check("stream_occ_ready", {31'd0, bus.in_ready},  32'd1);
    check("stream_head",      {28'd0, bus.out_data},  {28'd0, stream_tbl[1][3:0]});

    // Fill, then reset with both handshakes active
    send(4'b1100, 2'b01, 4'b0110, 1'b1);
    check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rst2_out_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst2_in_ready",  {31'd0, bus.in_ready},  32'd1);
    check("rst2_word_cnt",  {24'd0, bus.word_cnt},  32'd0);
    check("rst2_out_data",  {28'd0, bus.out_data},  32'd0);

    // Narrow counter saturates at 3 over 5 pops
    bus2.in_valid  = 1'b1;
    bus2.in_data   = 4'b1010;
    bus2.in_shift  = 2'b00;
    bus2.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("sat_cnt_3_pops", {30'd0, bus2.word_cnt}, 32'd3);
    step();
    bus2.in_valid = 1'b0;
    step();
    check("sat_cnt_5_pops", {30'd0, bus2.word_cnt}, 32'd3);
    check("sat_drained",    {31'd0, bus2.out_valid}, 32'd0);

    step();
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
